// File: rtl/nbbpu_pkg.sv
// Shared NBBPU definitions: opcode encodings, sequencer state codes and control-bundle layout.
package nbbpu_pkg;

  localparam int CTRL_W = 7;

  // Bit positions inside the control bundle, MSB first.
  localparam int CTRL_INSTRUCTION_ENABLE = 6;
  localparam int CTRL_READ_ENABLE        = 5;
  localparam int CTRL_REG_WRITE          = 4;
  localparam int CTRL_REG_SET            = 3;
  localparam int CTRL_WRITE_ENABLE       = 2;
  localparam int CTRL_JUMP_PC            = 1;
  localparam int CTRL_BRANCH_PC          = 0;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_CMP = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_BRZ = 4'h9;
  localparam logic [3:0] OP_BRN = 4'hA;
  localparam logic [3:0] OP_RES = 4'hB;
  localparam logic [3:0] OP_LOD = 4'hC;
  localparam logic [3:0] OP_STR = 4'hD;
  localparam logic [3:0] OP_SEL = 4'hE;
  localparam logic [3:0] OP_SEU = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEMWAIT = 3'd3,
    S_STORE   = 3'd4,
    S_HALT    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

endpackage

// File: rtl/nbbpu_control_decode.sv
// Purely combinational (state, opcode) -> control bundle decode for the NBBPU.
module nbbpu_control_decode
  import nbbpu_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   controls
);

  logic [3:0] op;
  logic       op_valid;

  // Opcodes wider than four bits decode as "no control" unless the upper bits are zero.
  always_comb begin
    op       = opcode[3:0];
    op_valid = ((opcode >> 4) == '0);
    controls = '0;
    case (state)
      S_FETCH: controls = 7'b1000000;
      S_DECODE: begin
        if (op_valid) begin
          case (op)
            OP_JMP:         controls = 7'b0000010;
            OP_BRZ, OP_BRN: controls = 7'b0000001;
            default:        controls = 7'b0000000;
          endcase
        end
      end
      S_EXECUTE, S_MEMWAIT: begin
        if (op_valid) begin
          case (op)
            OP_LOD:         controls = 7'b0100000;
            OP_STR:         controls = 7'b0000100;
            OP_SEL, OP_SEU: controls = 7'b0001000;
            OP_JMP:         controls = 7'b0000010;
            OP_BRZ, OP_BRN: controls = 7'b0000001;
            default:        controls = 7'b0000000;
          endcase
        end
      end
      S_STORE: begin
        if (op_valid) begin
          case (op)
            OP_JMP:         controls = 7'b1010010;
            OP_BRZ, OP_BRN: controls = 7'b1000001;
            OP_RES:         controls = 7'b1000000;
            OP_LOD:         controls = 7'b1110000;
            OP_STR:         controls = 7'b1000100;
            OP_SEL, OP_SEU: controls = 7'b1011000;
            default:        controls = 7'b1010000;
          endcase
        end
      end
      default: controls = '0;
    endcase
  end

endmodule

// File: rtl/nbbpu_sequencer.sv
// NBBPU instruction-cycle sequencer with ready stalls, wait timeout and single-step debug.
// Optional macro NBBPU_SEQ_RES_HALT_EN: RES parks the sequencer in HALT until step or reset.
module nbbpu_sequencer
  import nbbpu_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 200,
  parameter int OPCODE_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instruction_ready,
  input  logic                data_ready,
  input  logic                step_mode,
  input  logic                step,
  output logic                instruction_enable,
  output logic                read_enable,
  output logic                reg_write,
  output logic                reg_set,
  output logic                write_enable,
  output logic                jump_PC,
  output logic                branch_PC,
  output logic [2:0]          state,
  output logic                halted,
  output logic                fault
);

  state_t                cur_state, nxt_state;
  logic [OPCODE_W-1:0]   op_q;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic                  armed;
  logic                  paused, fetch_go, counting, timed_out, is_mem;
  logic [CTRL_W-1:0]     controls;

  // A step arriving together with instruction_ready is consumed in the same cycle.
  always_comb begin
    paused    = step_mode && !armed;
    fetch_go  = (cur_state == S_FETCH) && instruction_ready && (!paused || step);
    counting  = ((cur_state == S_FETCH) && !fetch_go && !paused) ||
                ((cur_state == S_MEMWAIT) && !data_ready);
    timed_out = counting && (wait_cnt == TIMEOUT_W'(TIMEOUT_MAX - 1));
    is_mem    = (op_q == OPCODE_W'(OP_LOD)) || (op_q == OPCODE_W'(OP_STR));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH: begin
        if (fetch_go)       nxt_state = S_DECODE;
        else if (timed_out) nxt_state = S_FAULT;
      end
      S_DECODE:  nxt_state = S_EXECUTE;
      S_EXECUTE: nxt_state = is_mem ? S_MEMWAIT : S_STORE;
      S_MEMWAIT: begin
        if (data_ready)     nxt_state = S_STORE;
        else if (timed_out) nxt_state = S_FAULT;
      end
`ifdef NBBPU_SEQ_RES_HALT_EN
      S_STORE:   nxt_state = (op_q == OPCODE_W'(OP_RES)) ? S_HALT : S_FETCH;
      S_HALT:    if (step) nxt_state = S_FETCH;
`else
      S_STORE:   nxt_state = S_FETCH;
      S_HALT:    nxt_state = S_FETCH;
`endif
      S_FAULT:   nxt_state = S_FAULT;
      default:   nxt_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      wait_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (fetch_go) op_q <= opcode;
      if (nxt_state != cur_state) wait_cnt <= '0;
      else if (counting)          wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      if (fetch_go)                                          armed <= 1'b0;
      else if ((cur_state == S_FETCH) && step_mode && step) armed <= 1'b1;
    end
  end

  nbbpu_control_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .state    (cur_state),
    .opcode   (op_q),
    .controls (controls)
  );

  always_comb begin
    instruction_enable = controls[CTRL_INSTRUCTION_ENABLE];
    read_enable        = controls[CTRL_READ_ENABLE];
    reg_write          = controls[CTRL_REG_WRITE];
    reg_set            = controls[CTRL_REG_SET];
    write_enable       = controls[CTRL_WRITE_ENABLE];
    jump_PC            = controls[CTRL_JUMP_PC];
    branch_PC          = controls[CTRL_BRANCH_PC];
    state              = cur_state;
    fault              = (cur_state == S_FAULT);
`ifdef NBBPU_SEQ_RES_HALT_EN
    halted             = (cur_state == S_HALT);
`else
    halted             = 1'b0;
`endif
  end

endmodule

// File: tb/tb_nbbpu_sequencer.sv
// Scoreboard bench for nbbpu_sequencer; expected per-cycle outputs are queued with the stimulus.
// Honours NBBPU_SEQ_RES_HALT_EN for the RES/HALT scenario.
module tb_nbbpu_sequencer;
  import nbbpu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = '0;
  logic       instruction_ready = 1'b0;
  logic       data_ready = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic       instruction_enable, read_enable, reg_write, reg_set;
  logic       write_enable, jump_PC, branch_PC, halted, fault;
  logic [2:0] state;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic        ir, dr, sm, st;
    logic [11:0] exp;
  } item_t;

  item_t sb[$];

  nbbpu_sequencer #(
    .TIMEOUT_W   (8),
    .TIMEOUT_MAX (10),
    .OPCODE_W    (4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .opcode             (opcode),
    .instruction_ready  (instruction_ready),
    .data_ready         (data_ready),
    .step_mode          (step_mode),
    .step               (step),
    .instruction_enable (instruction_enable),
    .read_enable        (read_enable),
    .reg_write          (reg_write),
    .reg_set            (reg_set),
    .write_enable       (write_enable),
    .jump_PC            (jump_PC),
    .branch_PC          (branch_PC),
    .state              (state),
    .halted             (halted),
    .fault              (fault)
  );

  always #5 clock = ~clock;

  assign obs = {state, instruction_enable, read_enable, reg_write, reg_set,
                write_enable, jump_PC, branch_PC, halted, fault};

  function automatic item_t mk(logic [3:0] op, logic ir, logic dr, logic sm, logic st,
                               logic [2:0] s, logic [6:0] c, logic h, logic f);
    item_t it;
    it.op = op; it.ir = ir; it.dr = dr; it.sm = sm; it.st = st;
    it.exp = {s, c, h, f};
    return it;
  endfunction

  task automatic drive(input item_t it);
    opcode = it.op; instruction_ready = it.ir; data_ready = it.dr;
    step_mode = it.sm; step = it.st;
  endtask

  // Leaves the bench 1 time unit after a rising edge with the DUT in FETCH.
  task automatic apply_reset();
    opcode = '0; instruction_ready = 0; data_ready = 0; step_mode = 0; step = 0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    item_t it;
    int n = 0;
    #1;
    checks++;
    if (obs !== {3'd0, 7'b1000000, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL reset_initial: got %b required %b", obs, {3'd0, 7'b1000000, 2'b00});
    end
    apply_reset();
    sb.push_back(mk(OP_LOD, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd1, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd2, 7'b0100000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd3, 7'b0100000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd3, 7'b0100000, 0, 0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); drive(it);
      @(negedge clock);
      checks++;
      if (obs !== it.exp) begin errors++; $display("[TB] FAIL reset_lod[%0d]: got %b required %b", n, obs, it.exp); end
      n++;
      @(posedge clock); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== {3'd0, 7'b1000000, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL reset_memwait: got %b required %b", obs, {3'd0, 7'b1000000, 2'b00});
    end
  endtask

  task automatic test_add();
    item_t it;
    int n = 0;
    apply_reset();
    sb.push_back(mk(OP_ADD, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd1, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd2, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd4, 7'b1010000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); drive(it);
      @(negedge clock);
      checks++;
      if (obs !== it.exp) begin errors++; $display("[TB] FAIL add[%0d]: got %b required %b", n, obs, it.exp); end
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_lod_wait();
    item_t it;
    int n = 0;
    apply_reset();
    sb.push_back(mk(OP_LOD, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd1, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd2, 7'b0100000, 0, 0));
    for (int i = 0; i < 4; i++)
      sb.push_back(mk(OP_ADD, 0, (i == 3), 0, 0, 3'd3, 7'b0100000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd4, 7'b1110000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); drive(it);
      @(negedge clock);
      checks++;
      if (obs !== it.exp) begin errors++; $display("[TB] FAIL lod_wait[%0d]: got %b required %b", n, obs, it.exp); end
      n++;
      @(posedge clock); #1;
    end
  endtask

  // data_ready on the last tolerated MEMWAIT cycle must still complete the access.
  task automatic test_timeout_boundary();
    item_t it;
    int n = 0;
    apply_reset();
    sb.push_back(mk(OP_STR, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd1, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd2, 7'b0000100, 0, 0));
    for (int i = 0; i < 10; i++)
      sb.push_back(mk(OP_ADD, 0, (i == 9), 0, 0, 3'd3, 7'b0000100, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd4, 7'b1000100, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); drive(it);
      @(negedge clock);
      checks++;
      if (obs !== it.exp) begin errors++; $display("[TB] FAIL boundary[%0d]: got %b required %b", n, obs, it.exp); end
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_str_timeout();
    item_t it;
    int n = 0;
    apply_reset();
    sb.push_back(mk(OP_STR, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd1, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd2, 7'b0000100, 0, 0));
    for (int i = 0; i < 10; i++)
      sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd3, 7'b0000100, 0, 0));
    for (int i = 0; i < 4; i++)
      sb.push_back(mk(OP_ADD, 1, 1, 0, 1, 3'd6, 7'b0000000, 0, 1));
    while (sb.size() != 0) begin
      it = sb.pop_front(); drive(it);
      @(negedge clock);
      checks++;
      if (obs !== it.exp) begin errors++; $display("[TB] FAIL timeout[%0d]: got %b required %b", n, obs, it.exp); end
      n++;
      @(posedge clock); #1;
    end
    apply_reset();
    checks++;
    if (obs !== {3'd0, 7'b1000000, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL timeout_clear: got %b required %b", obs, {3'd0, 7'b1000000, 2'b00});
    end
  endtask

  task automatic test_step_mode();
    item_t it;
    int n = 0;
    logic [2:0] s;
    logic [6:0] c;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      s = 3'd0; c = 7'b1000000;
      if (i == 6 || i == 21) begin s = 3'd1; c = 7'b0000000; end
      if (i == 7 || i == 22) begin s = 3'd2; c = 7'b0000000; end
      if (i == 8 || i == 23) begin s = 3'd4; c = 7'b1010000; end
      sb.push_back(mk(OP_SUB, 1, 0, 1, (i == 5 || i == 20), s, c, 0, 0));
    end
    // A step before the instruction is ready stays armed until it arrives.
    sb.push_back(mk(OP_XOR, 0, 0, 1, 1, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_XOR, 0, 0, 1, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_XOR, 0, 0, 1, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_XOR, 1, 0, 1, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_XOR, 1, 0, 1, 0, 3'd1, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_XOR, 1, 0, 1, 0, 3'd2, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_XOR, 1, 0, 1, 0, 3'd4, 7'b1010000, 0, 0));
    sb.push_back(mk(OP_XOR, 1, 0, 1, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_XOR, 1, 0, 1, 0, 3'd0, 7'b1000000, 0, 0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); drive(it);
      @(negedge clock);
      checks++;
      if (obs !== it.exp) begin errors++; $display("[TB] FAIL step[%0d]: got %b required %b", n, obs, it.exp); end
      n++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_res();
    item_t it;
    int n = 0;
    apply_reset();
    sb.push_back(mk(OP_RES, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd1, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd2, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd4, 7'b1000000, 0, 0));
`ifdef NBBPU_SEQ_RES_HALT_EN
    sb.push_back(mk(OP_ADD, 1, 0, 0, 0, 3'd5, 7'b0000000, 1, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 1, 3'd5, 7'b0000000, 1, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
`else
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
`endif
    while (sb.size() != 0) begin
      it = sb.pop_front(); drive(it);
      @(negedge clock);
      checks++;
      if (obs !== it.exp) begin errors++; $display("[TB] FAIL res[%0d]: got %b required %b", n, obs, it.exp); end
      n++;
      @(posedge clock); #1;
    end
  endtask

  // Opcode bus carries junk outside FETCH to show decode uses the latched opcode.
  task automatic test_back_to_back();
    item_t it;
    int n = 0;
    apply_reset();
    sb.push_back(mk(OP_JMP, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_STR, 1, 0, 0, 0, 3'd1, 7'b0000010, 0, 0));
    sb.push_back(mk(OP_LOD, 1, 0, 0, 0, 3'd2, 7'b0000010, 0, 0));
    sb.push_back(mk(OP_SEL, 1, 0, 0, 0, 3'd4, 7'b1010010, 0, 0));
    sb.push_back(mk(OP_BRZ, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_JMP, 1, 0, 0, 0, 3'd1, 7'b0000001, 0, 0));
    sb.push_back(mk(OP_STR, 1, 0, 0, 0, 3'd2, 7'b0000001, 0, 0));
    sb.push_back(mk(OP_LOD, 1, 0, 0, 0, 3'd4, 7'b1000001, 0, 0));
    sb.push_back(mk(OP_SEL, 1, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    sb.push_back(mk(OP_JMP, 1, 0, 0, 0, 3'd1, 7'b0000000, 0, 0));
    sb.push_back(mk(OP_BRN, 1, 0, 0, 0, 3'd2, 7'b0001000, 0, 0));
    sb.push_back(mk(OP_LOD, 1, 0, 0, 0, 3'd4, 7'b1011000, 0, 0));
    sb.push_back(mk(OP_ADD, 0, 0, 0, 0, 3'd0, 7'b1000000, 0, 0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); drive(it);
      @(negedge clock);
      checks++;
      if (obs !== it.exp) begin errors++; $display("[TB] FAIL b2b[%0d]: got %b required %b", n, obs, it.exp); end
      n++;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lod_wait();
    test_timeout_boundary();
    test_str_timeout();
    test_step_mode();
    test_res();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
